// File: rtl/memory_port_arbiter.sv
// Shares one unified memory port between instruction fetch and the load/store unit.
// Data wins arbitration, fetch is protected by a bounded starvation count, and every
// access is aborted with an error if memory stays silent for TIMEOUT_CYCLES cycles.
module memory_port_arbiter #(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetchRequest,
  input  logic [ADDR_WIDTH-1:0]   fetchAddress,
  output logic                    fetchGrant,
  output logic [DATA_WIDTH-1:0]   fetchData,
  output logic                    fetchError,
  input  logic                    dataRequest,
  input  logic                    dataWrite,
  input  logic [ADDR_WIDTH-1:0]   dataAddress,
  input  logic [DATA_WIDTH-1:0]   dataWriteData,
  input  logic [DATA_WIDTH/8-1:0] dataByteEnable,
  output logic                    dataGrant,
  output logic [DATA_WIDTH-1:0]   dataReadData,
  output logic                    dataError,
  output logic                    memRequest,
  output logic                    memWrite,
  output logic [ADDR_WIDTH-1:0]   memAddress,
  output logic [DATA_WIDTH-1:0]   memWriteData,
  output logic [DATA_WIDTH/8-1:0] memByteEnable,
  input  logic                    memReady,
  input  logic [DATA_WIDTH-1:0]   memReadData,
  output logic                    stallControl
);

  localparam int unsigned BeWidth     = DATA_WIDTH / 8;
  localparam int unsigned TimerWidth  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StarveWidth = $clog2(FETCH_STARVE_LIMIT + 1);
  localparam logic [TimerWidth-1:0]  TimeoutLast = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [StarveWidth-1:0] StarveMax   = StarveWidth'(FETCH_STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StDone} state_e;

  state_e                  r_state, w_state_next;
  logic [TimerWidth-1:0]   r_timer, w_timer_next;
  logic [StarveWidth-1:0]  r_starve, w_starve_next;
  logic                    r_mem_request, w_mem_request_next;
  logic                    r_mem_write, w_mem_write_next;
  logic [ADDR_WIDTH-1:0]   r_mem_address, w_mem_address_next;
  logic [DATA_WIDTH-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic [BeWidth-1:0]      r_mem_be, w_mem_be_next;
  logic                    r_fetch_grant, w_fetch_grant_next;
  logic [DATA_WIDTH-1:0]   r_fetch_data, w_fetch_data_next;
  logic                    r_fetch_error, w_fetch_error_next;
  logic                    r_data_grant, w_data_grant_next;
  logic [DATA_WIDTH-1:0]   r_data_rdata, w_data_rdata_next;
  logic                    r_data_error, w_data_error_next;
  logic                    w_data_wins;
  logic [DATA_WIDTH-1:0]   w_rsp_data;
  logic                    w_rsp_error;
  logic                    w_finish;

  // Data normally wins; once fetch has lost FETCH_STARVE_LIMIT times in a row it gets one turn.
  // A saturated count with no fetch pending must not block data, otherwise the port deadlocks.
  assign w_data_wins = dataRequest && (!fetchRequest || (r_starve < StarveMax));

  // Next-state, payload latching, completion and timeout handling.
  always_comb begin
    w_state_next       = r_state;
    w_timer_next       = r_timer;
    w_starve_next      = r_starve;
    w_mem_request_next = r_mem_request;
    w_mem_write_next   = r_mem_write;
    w_mem_address_next = r_mem_address;
    w_mem_wdata_next   = r_mem_wdata;
    w_mem_be_next      = r_mem_be;
    w_fetch_grant_next = 1'b0;
    w_fetch_data_next  = '0;
    w_fetch_error_next = 1'b0;
    w_data_grant_next  = 1'b0;
    w_data_rdata_next  = '0;
    w_data_error_next  = 1'b0;
    w_rsp_data         = '0;
    w_rsp_error        = 1'b0;
    w_finish           = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_data_wins) begin
          w_state_next       = StData;
          w_timer_next       = '0;
          w_mem_request_next = 1'b1;
          w_mem_write_next   = dataWrite;
          w_mem_address_next = dataAddress;
          w_mem_wdata_next   = dataWriteData;
          w_mem_be_next      = dataByteEnable;
          if (fetchRequest && (r_starve < StarveMax)) begin
            w_starve_next = r_starve + 1'b1;
          end
        end else if (fetchRequest) begin
          w_state_next       = StFetch;
          w_timer_next       = '0;
          w_starve_next      = '0;
          w_mem_request_next = 1'b1;
          w_mem_write_next   = 1'b0;
          w_mem_address_next = fetchAddress;
          w_mem_wdata_next   = '0;
          w_mem_be_next      = '1;
        end
      end
      StFetch, StData: begin
        if (memReady) begin
          w_finish   = 1'b1;
          w_rsp_data = r_mem_write ? '0 : memReadData;
        end else if (r_timer == TimeoutLast) begin
          w_finish    = 1'b1;
          w_rsp_error = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
        if (w_finish) begin
          w_state_next       = StDone;
          w_mem_request_next = 1'b0;
          if (r_state == StData) begin
            w_data_grant_next = 1'b1;
            w_data_rdata_next = w_rsp_data;
            w_data_error_next = w_rsp_error;
          end else begin
            w_fetch_grant_next = 1'b1;
            w_fetch_data_next  = w_rsp_data;
            w_fetch_error_next = w_rsp_error;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_timer       <= '0;
      r_starve      <= '0;
      r_mem_request <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_fetch_grant <= 1'b0;
      r_fetch_data  <= '0;
      r_fetch_error <= 1'b0;
      r_data_grant  <= 1'b0;
      r_data_rdata  <= '0;
      r_data_error  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_starve      <= w_starve_next;
      r_mem_request <= w_mem_request_next;
      r_mem_write   <= w_mem_write_next;
      r_mem_address <= w_mem_address_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_mem_be      <= w_mem_be_next;
      r_fetch_grant <= w_fetch_grant_next;
      r_fetch_data  <= w_fetch_data_next;
      r_fetch_error <= w_fetch_error_next;
      r_data_grant  <= w_data_grant_next;
      r_data_rdata  <= w_data_rdata_next;
      r_data_error  <= w_data_error_next;
    end
  end

  assign fetchGrant    = r_fetch_grant;
  assign fetchData     = r_fetch_data;
  assign fetchError    = r_fetch_error;
  assign dataGrant     = r_data_grant;
  assign dataReadData  = r_data_rdata;
  assign dataError     = r_data_error;
  assign memRequest    = r_mem_request;
  assign memWrite      = r_mem_write;
  assign memAddress    = r_mem_address;
  assign memWriteData  = r_mem_wdata;
  assign memByteEnable = r_mem_be;
  assign stallControl  = dataRequest && !r_data_grant;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: fetch, priority, starvation, store, timeout, reset.
module tb_memory_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetchRequest;
  logic [AW-1:0] fetchAddress;
  logic          fetchGrant;
  logic [DW-1:0] fetchData;
  logic          fetchError;
  logic          dataRequest;
  logic          dataWrite;
  logic [AW-1:0] dataAddress;
  logic [DW-1:0] dataWriteData;
  logic [3:0]    dataByteEnable;
  logic          dataGrant;
  logic [DW-1:0] dataReadData;
  logic          dataError;
  logic          memRequest;
  logic          memWrite;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic [3:0]    memByteEnable;
  logic          memReady;
  logic [DW-1:0] memReadData;
  logic          stallControl;

  int errors = 0;
  int checks = 0;
  int grants;
  int req_cycles;
  logic [5:0] order;
  logic both_seen;

  memory_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8),
    .FETCH_STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fetchRequest(fetchRequest),
    .fetchAddress(fetchAddress),
    .fetchGrant(fetchGrant),
    .fetchData(fetchData),
    .fetchError(fetchError),
    .dataRequest(dataRequest),
    .dataWrite(dataWrite),
    .dataAddress(dataAddress),
    .dataWriteData(dataWriteData),
    .dataByteEnable(dataByteEnable),
    .dataGrant(dataGrant),
    .dataReadData(dataReadData),
    .dataError(dataError),
    .memRequest(memRequest),
    .memWrite(memWrite),
    .memAddress(memAddress),
    .memWriteData(memWriteData),
    .memByteEnable(memByteEnable),
    .memReady(memReady),
    .memReadData(memReadData),
    .stallControl(stallControl)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; fetchRequest = 1'b0; fetchAddress = '0;
    dataRequest = 1'b0; dataWrite = 1'b0; dataAddress = '0;
    dataWriteData = '0; dataByteEnable = '0; memReady = 1'b0; memReadData = '0;
    tick(); tick();
    check("rst_memRequest", memRequest, 0);
    check("rst_memAddress", memAddress, 0);
    check("rst_fetchGrant", fetchGrant, 0);
    check("rst_dataGrant", dataGrant, 0);
    check("rst_stall", stallControl, 0);
    reset = 1'b1;
    tick();

    // Fetch 0x100, memReady two cycles after memRequest.
    fetchRequest = 1'b1; fetchAddress = 32'h100;
    tick();
    check("f1_memRequest", memRequest, 1);
    check("f1_memAddress", memAddress, 32'h100);
    check("f1_memWrite", memWrite, 0);
    check("f1_memBE", memByteEnable, 4'hF);
    tick();
    check("f1_wait_grant", fetchGrant, 0);
    check("f1_wait_req", memRequest, 1);
    tick();
    memReady = 1'b1; memReadData = 32'hDEADBEEF;
    tick();
    check("f1_grant", fetchGrant, 1);
    check("f1_data", fetchData, 32'hDEADBEEF);
    check("f1_error", fetchError, 0);
    check("f1_req_drop", memRequest, 0);
    fetchRequest = 1'b0; memReady = 1'b0;
    tick();
    check("f1_grant_pulse", fetchGrant, 0);
    check("f1_data_clear", fetchData, 0);

    // Simultaneous fetch and load: data first.
    fetchRequest = 1'b1; fetchAddress = 32'h104;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h2000;
    #1;
    check("p_stall_pre", stallControl, 1);
    tick();
    check("p_data_addr", memAddress, 32'h2000);
    check("p_data_req", memRequest, 1);
    check("p_stall_mid", stallControl, 1);
    memReady = 1'b1; memReadData = 32'hCAFEF00D;
    tick();
    check("p_dgrant", dataGrant, 1);
    check("p_fgrant_low", fetchGrant, 0);
    check("p_drdata", dataReadData, 32'hCAFEF00D);
    check("p_stall_done", stallControl, 0);
    dataRequest = 1'b0; memReady = 1'b0;
    tick();
    check("p_idle_req", memRequest, 0);
    tick();
    check("p_fetch_addr", memAddress, 32'h104);
    check("p_fetch_req", memRequest, 1);
    memReady = 1'b1; memReadData = 32'h11112222;
    tick();
    check("p_fgrant", fetchGrant, 1);
    check("p_fdata", fetchData, 32'h11112222);
    fetchRequest = 1'b0; memReady = 1'b0;
    tick();

    // Continuous data with fetch pending: D D D D F D.
    fetchRequest = 1'b1; fetchAddress = 32'h200;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h2100;
    memReady = 1'b1; memReadData = 32'h55AA55AA;
    grants = 0; order = '0; both_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (fetchGrant && dataGrant) both_seen = 1'b1;
      if (fetchGrant || dataGrant) begin
        grants++;
        order = {order[4:0], dataGrant};
      end
    end
    check("s_grant_count", grants, 6);
    check("s_order", order, 6'b111101);
    check("s_no_dual_grant", both_seen, 0);
    fetchRequest = 1'b0; dataRequest = 1'b0; memReady = 1'b0;
    tick();

    // Store with immediate memReady.
    dataRequest = 1'b1; dataWrite = 1'b1; dataAddress = 32'h3000;
    dataWriteData = 32'h1234; dataByteEnable = 4'b0011;
    memReady = 1'b1; memReadData = 32'hFFFFFFFF;
    tick();
    check("st_memWrite", memWrite, 1);
    check("st_memBE", memByteEnable, 4'b0011);
    check("st_memWdata", memWriteData, 32'h1234);
    check("st_memAddr", memAddress, 32'h3000);
    tick();
    check("st_dgrant", dataGrant, 1);
    check("st_rdata_zero", dataReadData, 0);
    check("st_error", dataError, 0);
    dataRequest = 1'b0; memReady = 1'b0;
    tick();

    // Load timeout; request dropped and payload changed after issue.
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h4000; dataByteEnable = 4'hF;
    tick();
    check("to_req", memRequest, 1);
    dataRequest = 1'b0; dataAddress = 32'h5555;
    req_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) check("to_addr_held", memAddress, 32'h4000);
      if (!memRequest) break;
      req_cycles++;
    end
    check("to_req_cycles", req_cycles, 8);
    check("to_dgrant", dataGrant, 1);
    check("to_derror", dataError, 1);
    check("to_rdata", dataReadData, 0);
    tick();
    check("to_grant_clear", dataGrant, 0);
    check("to_error_clear", dataError, 0);

    // Reset while in DATA.
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h6000;
    tick();
    check("r_in_data", memRequest, 1);
    reset = 1'b0; dataRequest = 1'b0;
    tick();
    check("r_memRequest", memRequest, 0);
    check("r_memAddress", memAddress, 0);
    check("r_dataGrant", dataGrant, 0);
    reset = 1'b1; memReady = 1'b1; memReadData = 32'h77777777;
    tick();
    check("r_post1_grant", dataGrant, 0);
    check("r_post1_req", memRequest, 0);
    tick();
    check("r_post2_grant", dataGrant, 0);
    check("r_post2_fgrant", fetchGrant, 0);
    check("r_post2_rdata", dataReadData, 0);
    memReady = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
